fp_normalize_pack: RTL and testbench

//  Post-add stage of the single-precision FP adder. Takes the sign and the 25-bit signed-magnitude

---
 rtl/fp_pkg.sv | 18 +
 rtl/fp_normalize_pack_if.sv | 30 +++
 rtl/fp_pack.sv | 22 ++
 rtl/fp_normalize_pack.sv | 128 ++++++++++++
 tb/tb_fp_normalize_pack.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the FP adder post-add normalise/pack stage.
//   FP_EXP_W / FP_FRAC_W : default exponent and stored-fraction widths
//   EXP_MAX              : all-ones exponent (inf/NaN encoding)
//   state_e              : normaliser FSM states
//   POS_ZERO/POS_INF/NEG_INF : packed single-precision special patterns
package fp_pkg;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int FP_W      = 1 + FP_EXP_W + FP_FRAC_W;

  localparam logic [FP_EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_e;

  localparam logic [FP_W-1:0] POS_ZERO = '0;
  localparam logic [FP_W-1:0] POS_INF  = {1'b0, EXP_MAX, {FP_FRAC_W{1'b0}}};
  localparam logic [FP_W-1:0] NEG_INF  = {1'b1, EXP_MAX, {FP_FRAC_W{1'b0}}};
endpackage

// File: rtl/fp_normalize_pack_if.sv
// Handshake bundle between the mantissa adder, the normaliser and the result register.
//   in_*  : operand side (valid/ready, sign, aligned exponent, 25-bit magnitude sum)
//   out_* : result side (valid/ready, packed word, zero/overflow/underflow flags)
//   slave modport = normaliser, master modport = producer/consumer around it
interface fp_normalize_pack_if import fp_pkg::*; #(
  parameter int EXP_W  = FP_EXP_W,
  parameter int FRAC_W = FP_FRAC_W
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sign;
  logic [EXP_W-1:0]        in_exp;
  logic [FRAC_W+1:0]       in_mant;
  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_W+FRAC_W:0]   out_result;
  logic                    out_zero;
  logic                    out_overflow;
  logic                    out_underflow;

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_overflow, out_underflow
  );

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_overflow, out_underflow
  );
endinterface

// File: rtl/fp_pack.sv
// Combinational IEEE-754 word assembly with special-value override.
//   sign, expo, frac : normalised fields
//   isInf            : emit {sign, all-ones, 0} (takes precedence)
//   isZero           : emit {sign, 0, 0}; caller decides the sign of zero
//   word             : packed {sign, exp, frac}
module fp_pack import fp_pkg::*; #(
  parameter int EXP_W  = FP_EXP_W,
  parameter int FRAC_W = FP_FRAC_W
) (
  input  logic                  sign,
  input  logic [EXP_W-1:0]      expo,
  input  logic [FRAC_W-1:0]     frac,
  input  logic                  isZero,
  input  logic                  isInf,
  output logic [EXP_W+FRAC_W:0] word
);
  always_comb begin
    if (isInf)       word = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    else if (isZero) word = {sign, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
    else             word = {sign, expo, frac};
  end
endmodule

// File: rtl/fp_normalize_pack.sv
// Post-add normalise and pack stage of the single-precision adder.
// Normalises the 25-bit magnitude sum by one right shift or up to FRAC_W
// single-bit left shifts (one per cycle), then packs an IEEE-754 word.
// No denormals: anything that would need one is flushed to signed zero.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of fp_normalize_pack_if (operand in, result out)
module fp_normalize_pack import fp_pkg::*; #(
  parameter int EXP_W  = FP_EXP_W,
  parameter int FRAC_W = FP_FRAC_W
) (
  input logic               clk,
  input logic               rst,
  fp_normalize_pack_if.slave bus
);
  localparam int MW = FRAC_W + 2;
  localparam int RW = 1 + EXP_W + FRAC_W;
  // One extra exponent bit so the +1 on carry-out can never wrap silently.
  localparam logic [EXP_W:0] EXP_TOP = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);

  state_e          state;
  logic            signQ;
  logic [EXP_W:0]  expQ;
  logic [MW-1:0]   mantQ;

  logic            validQ, zeroQ, ovfQ, underQ;
  logic [RW-1:0]   resultQ;

  logic            signNxt, finish, zeroNxt, infNxt, underNxt;
  logic [EXP_W:0]  expNxt;
  logic [MW-1:0]   mantNxt;
  logic [RW-1:0]   word;

  always_comb begin
    signNxt  = signQ;
    expNxt   = expQ;
    mantNxt  = mantQ;
    finish   = 1'b0;
    zeroNxt  = 1'b0;
    infNxt   = 1'b0;
    underNxt = 1'b0;
    if (state == CHECK) begin
      if (expQ == EXP_TOP) begin
        finish = 1'b1; infNxt = 1'b1;
      end else if (mantQ == '0) begin
        finish = 1'b1; zeroNxt = 1'b1; signNxt = 1'b0;   // exact cancellation is +0
      end else if (expQ == '0) begin
        finish = 1'b1; zeroNxt = 1'b1; underNxt = 1'b1;
      end else if (mantQ[MW-1]) begin
        mantNxt = mantQ >> 1;                            // truncate: round toward zero
        expNxt  = expQ + EXP_ONE;
        finish  = 1'b1;
        infNxt  = (expNxt >= EXP_TOP);
      end else if (mantQ[FRAC_W]) begin
        finish = 1'b1;
      end else if (expQ == EXP_ONE) begin
        finish = 1'b1; zeroNxt = 1'b1; underNxt = 1'b1;
      end
    end else if (state == SHIFT) begin
      mantNxt = mantQ << 1;
      expNxt  = expQ - EXP_ONE;
      // Hidden bit wins over hitting the minimum exponent on the same step.
      if (mantNxt[FRAC_W]) begin
        finish = 1'b1;
      end else if (expNxt == EXP_ONE) begin
        finish = 1'b1; zeroNxt = 1'b1; underNxt = 1'b1;
      end
    end
  end

  fp_pack #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) pack (
    .sign   (signNxt),
    .expo   (expNxt[EXP_W-1:0]),
    .frac   (mantNxt[FRAC_W-1:0]),
    .isZero (zeroNxt),
    .isInf  (infNxt),
    .word   (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      signQ   <= 1'b0;
      expQ    <= '0;
      mantQ   <= '0;
      validQ  <= 1'b0;
      resultQ <= '0;
      zeroQ   <= 1'b0;
      ovfQ    <= 1'b0;
      underQ  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          signQ <= bus.in_sign;
          expQ  <= {1'b0, bus.in_exp};
          mantQ <= bus.in_mant;
          state <= CHECK;
        end
        CHECK, SHIFT: begin
          expQ  <= expNxt;
          mantQ <= mantNxt;
          if (finish) begin
            resultQ <= word;
            zeroQ   <= zeroNxt;
            ovfQ    <= infNxt;
            underQ  <= underNxt;
            validQ  <= 1'b1;
            state   <= DONE;
          end else begin
            state <= SHIFT;
          end
        end
        DONE: if (bus.out_ready) begin
          validQ <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready      = (state == IDLE) && !rst;
  assign bus.out_valid     = validQ;
  assign bus.out_result    = resultQ;
  assign bus.out_zero      = zeroQ;
  assign bus.out_overflow  = ovfQ;
  assign bus.out_underflow = underQ;
endmodule

// File: tb/tb_fp_normalize_pack.sv
// Randomised bench for fp_normalize_pack against a value-level reference model.
module tb_fp_normalize_pack;
  import fp_pkg::*;

  typedef struct {
    logic [31:0] res;
    bit          z, o, u;
    int          lat;   // edges from accept edge T to the edge sampling out_valid high
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_normalize_pack_if #(.EXP_W(8), .FRAC_W(23)) bus ();

  fp_normalize_pack dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int   checks = 0;
  int   errors = 0;
  bit   pinned = 1'b0;
  bit   pending = 1'b0;
  bit   seen = 1'b0;
  int   edges = 0;
  exp_t cur;

  // Reference: result from the numeric rules, latency from how many
  // left shifts are needed (or how many fit before exponent 1).
  function automatic exp_t model(bit s, int e, int m);
    exp_t r;
    int   k;
    r.res = 32'h0; r.z = 0; r.o = 0; r.u = 0; r.lat = 2;
    if (e == 255) begin
      r.res = {s, 8'hFF, 23'h0}; r.o = 1;
    end else if (m == 0) begin
      r.z = 1;
    end else if (e == 0) begin
      r.res = {s, 31'h0}; r.z = 1; r.u = 1;
    end else if (m >= (1 << 24)) begin
      if (e + 1 >= 255) begin
        r.res = {s, 8'hFF, 23'h0}; r.o = 1;
      end else begin
        r.res = {s, 8'(e + 1), 23'(m >> 1)};
      end
    end else begin
      k = 0;
      while ((m << k) < (1 << 23)) k++;
      if (e - k >= 1) begin
        r.res = {s, 8'(e - k), 23'(m << k)};
        r.lat = 2 + k;
      end else begin
        r.res = {s, 31'h0}; r.z = 1; r.u = 1;
        r.lat = 2 + (e - 1);
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, expv, $time);
    end
  endtask

  // Hand-derived values that pin the reference model.
  task automatic pin();
    exp_t r;
    r = model(0, 'h7F, 'h0800000);  chk("pin_one", r.res, 32'h3F800000); chk("pin_one_lat", r.lat, 2);
    r = model(0, 'h7F, 'h1000000);  chk("pin_two", r.res, 32'h40000000);
    r = model(0, 'h7F, 'h0000001);  chk("pin_tiny", r.res, 32'h34000000); chk("pin_tiny_lat", r.lat, 25);
    r = model(1, 'hFE, 'h1800000);  chk("pin_ovf", r.res, NEG_INF); chk("pin_ovf_flag", r.o, 1);
    r = model(0, 'hFF, 'h0123456);  chk("pin_inf", r.res, POS_INF);
    r = model(1, 'h40, 'h0);        chk("pin_zero", {r.res[31:1], r.z}, {POS_ZERO[31:1], 1'b1});
    r = model(1, 'h05, 'h0000100);  chk("pin_uf", r.res, 32'h80000000);
    chk("pin_uf_lat", r.lat, 6); chk("pin_uf_flags", {r.z, r.u}, 2'b11);
  endtask

  // Single compare process: tracks the accepted operand at the edge and
  // checks every output 1 time unit after each rising edge.
  always @(posedge clk) begin
    bit acc, hs, expV;
    if (!pinned) begin pin(); pinned = 1'b1; end
    acc = bus.in_valid && bus.in_ready && !rst;
    hs  = bus.out_valid && bus.out_ready;
    if (rst) begin
      pending = 1'b0; seen = 1'b0;
    end else begin
      if (pending && hs) pending = 1'b0;
      if (acc) begin
        pending = 1'b1; seen = 1'b0; edges = 0;
        cur = model(bus.in_sign, int'(bus.in_exp), int'(bus.in_mant));
      end else if (pending) begin
        edges++;
      end
    end
    #1;
    chk("in_ready", bus.in_ready, (!pending && !rst));
    if (rst) begin
      chk("rst_result", bus.out_result, 32'h0);
      chk("rst_flags", {bus.out_valid, bus.out_zero, bus.out_overflow, bus.out_underflow}, 0);
    end else if (!pending) begin
      chk("idle_valid", bus.out_valid, 0);
    end else begin
      expV = seen || (edges + 1 >= cur.lat);
      chk("out_valid", bus.out_valid, expV);
      if (bus.out_valid) begin
        seen = 1'b1;
        chk("result", bus.out_result, cur.res);
        chk("flags", {bus.out_zero, bus.out_overflow, bus.out_underflow}, {cur.z, cur.o, cur.u});
      end
    end
  end

  task automatic send(bit s, logic [7:0] e, logic [24:0] m, int stall, bit junk, int abortAt);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_sign = s; bus.in_exp = e; bus.in_mant = m;
    @(negedge clk);
    if (junk) begin
      bus.in_sign = ~s; bus.in_exp = ~e; bus.in_mant = 25'($urandom);
    end else begin
      bus.in_valid = 1'b0;
    end
    if (abortAt > 0) begin
      repeat (abortAt - 1) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0; bus.in_valid = 1'b0;
      return;
    end
    n = 0;
    while (!bus.out_valid && n < 60) begin @(negedge clk); n++; end
    repeat (stall) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0]  e;
    logic [24:0] m;
    int          r, b;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0; bus.in_mant = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    send(0, 8'h7F, 25'h0800000, 0, 0, 0);
    send(0, 8'h7F, 25'h1000000, 1, 0, 0);
    send(0, 8'h7F, 25'h0000001, 0, 0, 0);
    send(1, 8'hFE, 25'h1800000, 0, 0, 0);
    send(0, 8'hFF, 25'h0800000, 0, 0, 0);
    send(1, 8'h33, 25'h0000000, 0, 0, 0);
    send(1, 8'h05, 25'h0000100, 0, 0, 0);
    send(0, 8'h00, 25'h0C00000, 0, 0, 0);
    send(1, 8'h01, 25'h0400000, 0, 0, 0);
    send(0, 8'h02, 25'h0400000, 0, 0, 0);
    send(0, 8'h7F, 25'h0800000, 5, 1, 0);   // stalled DONE with junk on the input
    send(0, 8'h7F, 25'h0000001, 0, 0, 6);   // reset mid-SHIFT
    send(1, 8'h7F, 25'h0800000, 0, 0, 3);   // reset mid-DONE
    send(1, 8'h40, 25'h0A00000, 0, 0, 0);

    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0:       e = 8'h00;
        1:       e = 8'hFF;
        2:       e = 8'($urandom_range(1, 4));
        3:       e = 8'hFE;
        default: e = 8'($urandom_range(1, 254));
      endcase
      r = int'($urandom_range(0, 7));
      b = int'($urandom_range(0, 23));
      case (r)
        0:       m = '0;
        1:       m = 25'($urandom);
        2:       m = 25'h1000000 | 25'($urandom);
        default: m = 25'(($urandom & ((32'd1 << b) - 32'd1)) | (32'd1 << b));
      endcase
      send(1'($urandom), e, m, int'($urandom_range(0, 3)), 1'($urandom), 0);
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
